// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with prescaler, auto-reload,
// sticky expiry flag, level interrupt and a one-cycle expiry pulse.
module mmio_timer #(
  parameter int DATA_LENGTH    = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            Address,
  input  logic [DATA_LENGTH-1:0] DataIn,
  output logic [DATA_LENGTH-1:0] DataOut,
  input  logic                   Select,
  input  logic                   Write,
  output logic                   Irq,
  output logic                   Timer_Out
);
  logic                      en, auto_reload, irq_en, expired;
  logic [PRESCALE_WIDTH-1:0] prescale, psc_cnt;
  logic [DATA_LENGTH-1:0]    load, count, ctrl_rd;
  logic                      wr, wr_ctrl, wr_load, wr_count, wr_status, tick, expire;
  logic                      unused;
  assign unused    = ^{Address[31:4], Address[1:0]};
  assign wr        = Select & Write;
  assign wr_ctrl   = wr && Address[3:2] == 2'd0;
  assign wr_load   = wr && Address[3:2] == 2'd1;
  assign wr_count  = wr && Address[3:2] == 2'd2;
  assign wr_status = wr && Address[3:2] == 2'd3;
  assign tick      = en && psc_cnt == prescale;
  assign expire    = tick && count == '0;
  assign Irq       = expired & irq_en;
  assign ctrl_rd   = (DATA_LENGTH'(prescale) << 8) | DATA_LENGTH'({irq_en, auto_reload, en});
  assign DataOut   = !Select              ? '0 :
                     Address[3:2] == 2'd0 ? ctrl_rd :
                     Address[3:2] == 2'd1 ? load :
                     Address[3:2] == 2'd2 ? count :
                                            DATA_LENGTH'(expired);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
      psc_cnt     <= '0;
      load        <= '0;
      count       <= '0;
      expired     <= 1'b0;
      Timer_Out   <= 1'b0;
    end else begin
      psc_cnt <= (wr_ctrl || !en || tick) ? '0 : psc_cnt + PRESCALE_WIDTH'(1);
      if (wr_ctrl) begin
        en          <= DataIn[0];
        auto_reload <= DataIn[1];
        irq_en      <= DataIn[2];
        prescale    <= DataIn[8 +: PRESCALE_WIDTH];
      end else if (expire && !auto_reload) begin
        en <= 1'b0;
      end
      if (wr_load) load <= DataIn;
      // a direct COUNT write overrides whatever the tick would have done
      if (wr_count) count <= DataIn;
      else if (tick) count <= expire ? (auto_reload ? load : count) : count - DATA_LENGTH'(1);
      expired   <= expire | (expired & ~(wr_status & DataIn[0]));
      Timer_Out <= expire;
    end
  end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: register table vectors, directed corner cases and randomized
// timer programs checked against an arithmetic model of tick/expiry times.
module tb_mmio_timer;
  logic        clk = 0, rst = 0, Select = 0, Write = 0, Irq, Timer_Out;
  logic [31:0] Address = 0, DataIn = 0, DataOut;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  mmio_timer dut (
    .clk(clk), .rst(rst), .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
    .Select(Select), .Write(Write), .Irq(Irq), .Timer_Out(Timer_Out)
  );

  typedef struct {
    logic        sel;
    logic        wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Address = {28'd0, a, 2'b00}; DataIn = d; Select = 1; Write = 1;
    @(posedge clk); #1;
    Select = 0; Write = 0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    Address = {28'd0, a, 2'b00}; Select = 1; Write = 0;
    #1 chk(nm, DataOut, exp);
    Select = 0;
  endtask

  // tick number n (1-based since enable) is an expiry?
  function automatic bit is_exp(int n, int c, int l, int au);
    return n == c + 1 || (au != 0 && n > c + 1 && (n - c - 1) % (l + 1) == 0);
  endfunction

  // COUNT value after t ticks since enable
  function automatic int cnt_after(int t, int c, int l, int au);
    if (t <= c) return c - t;
    if (au == 0) return 0;
    return l - ((t - c - 1) % (l + 1));
  endfunction

  task automatic run_case(input int c, input int l, input int p, input int au, input int ie, input int n);
    int t, a, exp_data, to;
    bit fl;
    wr(0, 0); wr(3, 1); wr(1, l); wr(2, c);
    wr(0, (p << 8) | (ie << 2) | (au << 1) | 1);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      a = (k == n - 1) ? 3 : (k == n) ? 0 : 2;
      Address = a << 2; Select = 1; Write = 0;
      #1;
      t  = (k - 1) / (p + 1);
      fl = t >= c + 1;
      to = (k > 1 && (k - 1) % (p + 1) == 0 && is_exp((k - 1) / (p + 1), c, l, au)) ? 1 : 0;
      exp_data = (a == 3) ? int'(fl) :
                 (a == 0) ? ((p << 8) | (ie << 2) | (au << 1) | ((au != 0 || !fl) ? 1 : 0)) :
                            cnt_after(t, c, l, au);
      chk(a == 3 ? "status" : a == 0 ? "ctrl" : "count", DataOut, exp_data);
      chk("timer_out", {31'd0, Timer_Out}, to);
      chk("irq", {31'd0, Irq}, {31'd0, fl & (ie != 0)});
    end
    Select = 0;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 2'd0, 32'h0,        32'h0};
    vecs[1]  = '{1, 0, 2'd1, 32'h0,        32'h0};
    vecs[2]  = '{1, 0, 2'd2, 32'h0,        32'h0};
    vecs[3]  = '{1, 0, 2'd3, 32'h0,        32'h0};
    vecs[4]  = '{1, 1, 2'd1, 32'h12345678, 32'h12345678};
    vecs[5]  = '{0, 1, 2'd1, 32'hFFFFFFFF, 32'h12345678};
    vecs[6]  = '{1, 1, 2'd0, 32'hFFFFFFFE, 32'h0000FF06};
    vecs[7]  = '{1, 1, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8]  = '{1, 1, 2'd3, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1, 1, 2'd0, 32'h0,        32'h0};
    vecs[10] = '{1, 1, 2'd2, 32'h0,        32'h0};

    repeat (2) @(negedge clk);
    chk("reset_irq", {31'd0, Irq}, 0);
    chk("reset_timer_out", {31'd0, Timer_Out}, 0);
    rst = 1;

    foreach (vecs[i]) begin
      @(negedge clk);
      Address = {28'd0, vecs[i].a, 2'b00}; DataIn = vecs[i].d; Select = vecs[i].sel; Write = vecs[i].wr;
      @(posedge clk); #1;
      Select = 0; Write = 0;
      rd(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    Address = 4; Select = 0;
    #1 chk("deselect_read", DataOut, 0);

    run_case(3, 3, 0, 1, 0, 14);
    run_case(2, 7, 4, 0, 1, 20);
    @(negedge clk); #1 chk("irq_held", {31'd0, Irq}, 1);
    wr(3, 0);
    @(negedge clk); #1 chk("irq_after_zero_write", {31'd0, Irq}, 1);
    wr(3, 1);
    @(negedge clk); #1 chk("irq_after_clear", {31'd0, Irq}, 0);
    rd(3, 0, "status_cleared");

    wr(0, 0); wr(3, 1); wr(2, 0); wr(0, 1); wr(3, 1);
    rd(3, 1, "status_set_wins");
    chk("timer_out_on_clear", {31'd0, Timer_Out}, 1);
    rd(0, 0, "oneshot_en_off");

    wr(0, 0); wr(2, 100); wr(0, 1); wr(2, 32'h10);
    rd(2, 32'h10, "count_write_wins");

    wr(0, 0); wr(1, 5); wr(2, 0); wr(0, 3); wr(1, 9);
    rd(2, 5, "reload_old_load");
    rd(1, 9, "load_new");

    wr(0, 0); wr(2, 7); wr(0, 1); wr(0, 0);
    rd(2, 6, "ctrl_write_on_tick_count");
    rd(0, 0, "ctrl_write_on_tick_en");

    repeat (25)
      run_case($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), 40);

    wr(0, 0); wr(3, 1); wr(1, 5); wr(2, 0); wr(0, 7);
    @(posedge clk);
    @(negedge clk);
    Address = 8; Select = 1;
    #1 chk("pre_reset_count", DataOut, 5);
    chk("pre_reset_irq", {31'd0, Irq}, 1);
    #2 rst = 0;
    #1 chk("async_irq", {31'd0, Irq}, 0);
    chk("async_count", DataOut, 0);
    chk("async_timer_out", {31'd0, Timer_Out}, 0);
    Select = 0;
    for (int a = 0; a < 4; a++) rd(a[1:0], 0, "in_reset_read");
    @(negedge clk) rst = 1;
    repeat (6) begin
      rd(2, 0, "post_reset_count");
      chk("post_reset_timer_out", {31'd0, Timer_Out}, 0);
    end
    rd(0, 0, "post_reset_ctrl");
    rd(3, 0, "post_reset_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
